// File: rtl/dreg_pipe_pkg.sv
// dreg_pipe_pkg: shared definitions for the multi-stage DTI data register.
//   clog2       - ceiling log2, used to size the occupancy counter
//   PASS / SKID - stage mode selectors (pass-through ready / registered ready)
//   stage_state_e - per-stage state of the skid-mode stage machine
package dreg_pipe_pkg;

  localparam int PASS = 0;
  localparam int SKID = 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // main register invalid
    ST_BUSY  = 2'd1,  // main valid, skid empty
    ST_FULL  = 2'd2   // main and skid both valid, stage not ready
  } stage_state_e;

  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/dreg_pipe_if.sv
// dreg_pipe_if: one DTI valid/ready channel.
//   valid - producer has a word on data
//   data  - the word, DIN bits
//   ready - consumer can take the word
// Handshake: a word moves on a rising edge where valid && ready. Once valid
// is raised it and data hold until that edge; valid never depends
// combinationally on ready.
//   master modport: drives valid/data, samples ready
//   slave  modport: samples valid/data, drives ready
interface dreg_pipe_if #(
  parameter int DIN = 16
);
  logic           valid;
  logic [DIN-1:0] data;
  logic           ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/dreg_stage.sv
// dreg_stage: one register stage of dreg_pipe.
//   clk, rst            - clock, synchronous active-low reset
//   in_valid/in_data    - upstream word
//   in_ready            - stage accepts the upstream word this cycle
//   out_valid/out_data  - word presented downstream
//   out_ready           - downstream accepts the word
//   state_dbg           - stage state (EMPTY/BUSY/FULL encoding)
// SKID=PASS: single register, ready is combinational from downstream.
// SKID=SKID: main + skid register under a 3-state machine, ready is a flop.
// INIT/INIT_VALID set the reset contents (the top enables INIT_VALID only on
// the output stage).
module dreg_stage
  import dreg_pipe_pkg::*;
#(
  parameter int             DIN        = 16,
  parameter int             SKID       = 0,
  parameter logic [DIN-1:0] INIT       = '0,
  parameter bit             INIT_VALID = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [DIN-1:0] in_data,
  output logic           in_ready,
  output logic           out_valid,
  output logic [DIN-1:0] out_data,
  input  logic           out_ready,
  output logic [1:0]     state_dbg
);

  if (SKID == dreg_pipe_pkg::SKID) begin : g_skid
    stage_state_e   state_q;
    stage_state_e   state_d;
    logic [DIN-1:0] main_q;
    logic [DIN-1:0] skid_q;
    logic           ready_q;
    logic           in_hs;
    logic           out_hs;
    logic           load_main_in;
    logic           load_main_skid;
    logic           load_skid;

    assign in_hs  = in_valid && ready_q;
    assign out_hs = (state_q != ST_EMPTY) && out_ready;

    always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state_q)
        ST_EMPTY: begin
          if (in_hs) begin
            load_main_in = 1'b1;
            state_d      = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (in_hs && out_hs) begin
            load_main_in = 1'b1;
          end else if (in_hs) begin
            load_skid = 1'b1;
            state_d   = ST_FULL;
          end else if (out_hs) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // ready_q is low here, so no new word can arrive alongside.
          if (out_hs) begin
            load_main_skid = 1'b1;
            state_d        = ST_BUSY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        state_q <= INIT_VALID ? ST_BUSY : ST_EMPTY;
        ready_q <= 1'b1;
        main_q  <= INIT;
      end else begin
        state_q <= state_d;
        // Registered copy of (state != FULL): tracks state exactly but is a
        // pure flop, so upstream never sees a path from out_ready.
        ready_q <= (state_d != ST_FULL);
        if (load_main_in) begin
          main_q <= in_data;
        end else if (load_main_skid) begin
          main_q <= skid_q;
        end
      end
    end

    // Skid contents are only meaningful in FULL, so no reset is needed.
    always_ff @(posedge clk) begin
      if (load_skid) begin
        skid_q <= in_data;
      end
    end

    assign in_ready  = ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign state_dbg = state_q;

  end else begin : g_pass
    logic           valid_q;
    logic [DIN-1:0] data_q;

    // An empty stage is always ready, which collapses bubbles.
    assign in_ready = !valid_q || out_ready;

    always_ff @(posedge clk) begin
      if (!rst) begin
        valid_q <= INIT_VALID;
        data_q  <= INIT;
      end else if (in_ready) begin
        valid_q <= in_valid;
        if (in_valid) begin
          data_q <= in_data;
        end
      end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign state_dbg = valid_q ? ST_BUSY : ST_EMPTY;
  end

endmodule

// File: rtl/dreg_pipe.sv
// dreg_pipe: DEPTH chained DTI register stages with an occupancy counter.
//   clk, rst    - clock, synchronous active-low reset
//   din         - producer channel (slave side)
//   dout        - consumer channel (master side)
//   count       - number of valid words held (0 .. capacity)
//   stage_state - per-stage state, 2 bits per stage, stage 0 in [1:0]
// SKID=PASS: capacity DEPTH, din.ready combinational from dout.ready.
// SKID=SKID: capacity 2*DEPTH, din.ready is a flop output.
module dreg_pipe
  import dreg_pipe_pkg::*;
#(
  parameter int             DIN        = 16,
  parameter int             DEPTH      = 1,
  parameter int             SKID       = 0,
  parameter logic [DIN-1:0] INIT       = '0,
  parameter bit             INIT_VALID = 1'b0,
  localparam int            CNT_W      = clog2(2 * DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  dreg_pipe_if.slave         din,
  dreg_pipe_if.master        dout,
  output logic [CNT_W-1:0]   count,
  output logic [2*DEPTH-1:0] stage_state
);

  // Each generate scope owns its own link signals; neighbours are reached by
  // index so the pass-through ready chain is a plain wire chain.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic           up_valid;
    logic [DIN-1:0] up_data;
    logic           i_ready;
    logic           o_valid;
    logic [DIN-1:0] o_data;
    logic           dn_ready;
    logic [1:0]     st_dbg;

    if (k == 0) begin : g_first
      assign up_valid  = din.valid;
      assign up_data   = din.data;
      assign din.ready = i_ready;
    end else begin : g_link
      assign up_valid = g_stage[k-1].o_valid;
      assign up_data  = g_stage[k-1].o_data;
    end

    if (k == DEPTH - 1) begin : g_last
      assign dn_ready   = dout.ready;
      assign dout.valid = o_valid;
      assign dout.data  = o_data;
    end else begin : g_inner
      assign dn_ready = g_stage[k+1].i_ready;
    end

    dreg_stage #(
      .DIN        (DIN),
      .SKID       (SKID),
      .INIT       (INIT),
      .INIT_VALID ((k == DEPTH - 1) ? INIT_VALID : 1'b0)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (up_valid),
      .in_data   (up_data),
      .in_ready  (i_ready),
      .out_valid (o_valid),
      .out_data  (o_data),
      .out_ready (dn_ready),
      .state_dbg (st_dbg)
    );

    assign stage_state[2*k +: 2] = st_dbg;
  end

  logic in_hs;
  logic out_hs;

  assign in_hs  = din.valid && din.ready;
  assign out_hs = dout.valid && dout.ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= CNT_W'(INIT_VALID);
    end else if (in_hs && !out_hs) begin
      count <= count + 1'b1;
    end else if (!in_hs && out_hs) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_dreg_pipe.sv
// tb_dreg_pipe: directed bench for dreg_pipe. Four configurations share one
// stimulus bus; sel picks which one is observed and scoreboarded.
//   0: DEPTH=3 pass      1: DEPTH=2 skid
//   2: DEPTH=2 pass INIT=0xAB INIT_VALID=1      3: DEPTH=3 skid
module tb_dreg_pipe;
  import dreg_pipe_pkg::*;

  localparam int P_DEPTH [4] = '{3, 2, 2, 3};
  localparam int P_SKID  [4] = '{PASS, SKID, PASS, SKID};
  localparam bit P_IV    [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // stimulus bus
  logic        din_valid;
  logic [15:0] din_data;
  logic        dout_ready;

  logic        obs_ready [4];
  logic        obs_valid [4];
  logic [15:0] obs_data  [4];
  logic [7:0]  obs_count [4];
  logic [7:0]  obs_state [4];

  for (genvar i = 0; i < 4; i++) begin : g_dut
    dreg_pipe_if #(.DIN(16)) din_if ();
    dreg_pipe_if #(.DIN(16)) dout_if ();
    logic [clog2(2*P_DEPTH[i]+1)-1:0] cnt;
    logic [2*P_DEPTH[i]-1:0]          st;

    assign din_if.valid  = din_valid;
    assign din_if.data   = din_data;
    assign dout_if.ready = dout_ready;

    dreg_pipe #(
      .DIN        (16),
      .DEPTH      (P_DEPTH[i]),
      .SKID       (P_SKID[i]),
      .INIT       (16'hAB),
      .INIT_VALID (P_IV[i])
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .din         (din_if),
      .dout        (dout_if),
      .count       (cnt),
      .stage_state (st)
    );

    assign obs_ready[i] = din_if.ready;
    assign obs_valid[i] = dout_if.valid;
    assign obs_data[i]  = dout_if.data;
    assign obs_count[i] = 8'(cnt);
    assign obs_state[i] = 8'(st);
  end

  logic [1:0]  sel;
  logic        cur_ready;
  logic        cur_valid;
  logic [15:0] cur_data;
  logic [7:0]  cur_count;
  logic [7:0]  cur_state;

  always_comb begin
    cur_ready = obs_ready[sel];
    cur_valid = obs_valid[sel];
    cur_data  = obs_data[sel];
    cur_count = obs_count[sel];
    cur_state = obs_state[sel];
  end

  // scoreboard
  logic [15:0] exp_q [$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_out;
  int          cyc = 0;
  logic        in_hs_last;
  logic        out_hs_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: evaluate handshakes mid-cycle, advance, then check occupancy.
  task automatic tick();
    logic ih;
    logic oh;
    @(negedge clk);
    ih = din_valid && cur_ready;
    oh = cur_valid && dout_ready;
    if (rst) begin
      if (oh) begin
        if (exp_q.size() == 0) begin
          check("dout_extra", 32'(cur_valid), 32'd0);
        end else begin
          check("dout_data", 32'(cur_data), 32'(exp_q.pop_front()));
          n_out++;
        end
      end
      if (ih) exp_q.push_back(din_data);
    end else begin
      ih = 1'b0;
      oh = 1'b0;
    end
    in_hs_last  = ih;
    out_hs_last = oh;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      exp_q.delete();
      if (sel == 2'd2) exp_q.push_back(16'hAB);
    end
    #1;
    check("count", 32'(cur_count), 32'(exp_q.size()));
  endtask

  task automatic do_reset(input int cycles);
    rst       = 1'b0;
    din_valid = 1'b0;
    for (int i = 0; i < cycles; i++) tick();
    rst   = 1'b1;
    n_out = 0;
  endtask

  int   nxt;
  int   first_acc;
  int   first_vld;
  int   first_out;
  int   last_out;
  logic saw_ready;
  logic prev_dr;
  logic r0;

  initial begin
    rst        = 1'b0;
    din_valid  = 1'b0;
    din_data   = '0;
    dout_ready = 1'b1;
    sel        = 2'd0;
    n_out      = 0;

    // 1 / 6-pass: DEPTH=3 pass-through, stream 0..9 with dout_ready=1
    sel = 2'd0;
    dout_ready = 1'b1;
    do_reset(2);
    check("t1_rst_valid", 32'(cur_valid), 32'd0);
    check("t1_rst_ready", 32'(cur_ready), 32'd1);
    nxt = 0; first_acc = -1; first_vld = -1; first_out = -1; last_out = -1;
    for (int c = 0; c < 16; c++) begin
      din_valid = (nxt < 10);
      din_data  = 16'(nxt);
      tick();
      if (in_hs_last) begin
        if (first_acc < 0) first_acc = cyc;
        nxt++;
      end
      if (out_hs_last) begin
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      if (cur_valid && first_vld < 0) first_vld = cyc;
      if (c >= 4 && c <= 8) begin
        check("t1_steady_count", 32'(cur_count), 32'd3);
        check("t1_steady_in", 32'(in_hs_last), 32'd1);
        check("t1_steady_out", 32'(out_hs_last), 32'd1);
      end
    end
    check("t1_latency", 32'(first_vld - first_acc), 32'd2);
    check("t1_no_gaps", 32'(last_out - first_out), 32'd9);
    check("t1_n_out", 32'(n_out), 32'd10);
    check("t1_end_valid", 32'(cur_valid), 32'd0);

    // 2: DEPTH=2 skid, stalled consumer, stream 1..6
    sel = 2'd1;
    do_reset(2);
    check("t2_rst_ready", 32'(cur_ready), 32'd1);
    check("t2_rst_valid", 32'(cur_valid), 32'd0);
    dout_ready = 1'b0;
    nxt = 1;
    for (int c = 0; c < 6; c++) begin
      din_valid = (nxt <= 6);
      din_data  = 16'(nxt);
      tick();
      if (in_hs_last) nxt++;
    end
    check("t2_accepts", 32'(nxt - 1), 32'd4);
    check("t2_full_count", 32'(cur_count), 32'd4);
    check("t2_full_ready", 32'(cur_ready), 32'd0);
    check("t2_head_data", 32'(cur_data), 32'd1);
    check("t2_full_state", 32'(cur_state), 32'h0A);
    dout_ready = 1'b1;
    saw_ready  = 1'b0;
    for (int c = 0; c < 14; c++) begin
      din_valid = (nxt <= 6);
      din_data  = 16'(nxt);
      tick();
      if (in_hs_last) nxt++;
      if (cur_ready) saw_ready = 1'b1;
    end
    check("t2_reassert", 32'(saw_ready), 32'd1);
    check("t2_n_out", 32'(n_out), 32'd6);
    check("t2_all_in", 32'(nxt), 32'd7);

    // 6-skid: fill, then run in/out every cycle
    dout_ready = 1'b0;
    nxt = 0;
    for (int c = 0; c < 6; c++) begin
      din_valid = 1'b1;
      din_data  = 16'h100 + 16'(nxt);
      tick();
      if (in_hs_last) nxt++;
    end
    check("t6_full_count", 32'(cur_count), 32'd4);
    dout_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      din_valid = 1'b1;
      din_data  = 16'h100 + 16'(nxt);
      tick();
      if (in_hs_last) nxt++;
      if (c >= 4) begin
        check("t6_in", 32'(in_hs_last), 32'd1);
        check("t6_out", 32'(out_hs_last), 32'd1);
        check("t6_count", 32'(cur_count), 32'd2);
      end
    end
    din_valid = 1'b0;
    for (int c = 0; c < 8; c++) tick();

    // 3: DEPTH=2 pass with INIT_VALID, reset held two cycles
    sel = 2'd2;
    dout_ready = 1'b0;
    do_reset(2);
    check("t3_init_valid", 32'(cur_valid), 32'd1);
    check("t3_init_data", 32'(cur_data), 32'hAB);
    check("t3_init_count", 32'(cur_count), 32'd1);
    check("t3_init_ready", 32'(cur_ready), 32'd1);
    din_valid = 1'b1;
    din_data  = 16'h11;
    tick();
    din_valid = 1'b0;
    check("t3_backpressure", 32'(cur_ready), 32'd0);
    dout_ready = 1'b1;
    #1;
    check("t3_ready_comb", 32'(cur_ready), 32'd1);
    for (int c = 0; c < 4; c++) tick();
    check("t3_n_out", 32'(n_out), 32'd2);

    // 5: DEPTH=3 skid, reset with five words held and one in flight
    sel = 2'd3;
    dout_ready = 1'b0;
    do_reset(2);
    nxt = 0;
    for (int c = 0; c < 10; c++) begin
      din_valid = (nxt < 5);
      din_data  = 16'h50 + 16'(nxt);
      tick();
      if (in_hs_last) nxt++;
    end
    check("t5_pre_count", 32'(cur_count), 32'd5);
    din_valid = 1'b1;
    din_data  = 16'h99;
    rst       = 1'b0;
    tick();
    rst       = 1'b1;
    din_valid = 1'b0;
    n_out     = 0;
    check("t5_rst_count", 32'(cur_count), 32'd0);
    check("t5_rst_valid", 32'(cur_valid), 32'd0);
    check("t5_rst_ready", 32'(cur_ready), 32'd1);
    check("t5_rst_state", 32'(cur_state), 32'd0);
    din_valid  = 1'b1;
    din_data   = 16'h77;
    dout_ready = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    check("t5_n_out", 32'(n_out), 32'd1);

    // 4: DEPTH=2 skid, random valid/ready
    sel = 2'd1;
    do_reset(2);
    in_hs_last = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      prev_dr = dout_ready;
      r0      = cur_ready;
      if (!(din_valid && !in_hs_last)) begin
        din_valid = 1'($urandom_range(0, 1));
        din_data  = 16'($urandom_range(0, 16'hFFFF));
      end
      dout_ready = 1'($urandom_range(0, 1));
      #1;
      if (dout_ready != prev_dr) check("t4_ready_comb", 32'(cur_ready), 32'(r0));
      tick();
    end
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    check("t4_drained", 32'(cur_count), 32'd0);
    check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
